// File: rtl/icache_responder.sv
// Direct-mapped, one-word-per-line instruction cache responder.
// Hits answer in one cycle; misses fill the line from byte-wide memory over four reads.
module icache_responder #(
    parameter int unsigned INDEX_BITS = 6,
    parameter int unsigned ADDR_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  ena,
    input  logic                  flush,
    input  logic                  fetch_req,
    input  logic [ADDR_WIDTH-1:0] fetch_pc,
    output logic                  fetch_ready,
    output logic                  inst_valid,
    output logic [31:0]           inst,
    output logic                  mem_valid,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    input  logic [7:0]            mem_din
);

    localparam int unsigned Lines   = 2 ** INDEX_BITS;
    localparam int unsigned TagBits = ADDR_WIDTH - INDEX_BITS - 2;

    typedef enum logic [0:0] {StIdle, StFill} state_e;

    state_e state_q, state_d;

    logic [Lines-1:0]   valid_q;
    logic [TagBits-1:0] tag_q  [Lines];
    logic [31:0]        data_q [Lines];

    logic [2:0]            cnt_q, cnt_d;
    logic [23:0]           buf_q, buf_d;
    logic [ADDR_WIDTH-1:0] base_q, base_d;
    logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
    logic                  mem_valid_q, mem_valid_d;
    logic                  inst_valid_q, inst_valid_d;
    logic [31:0]           inst_q, inst_d;
    logic                  line_we;

    logic [INDEX_BITS-1:0] req_idx, fill_idx;
    logic [TagBits-1:0]    req_tag, fill_tag;
    logic                  hit;
    logic [31:0]           line_word;

    assign req_idx   = fetch_pc[INDEX_BITS+1:2];
    assign req_tag   = fetch_pc[ADDR_WIDTH-1:INDEX_BITS+2];
    assign fill_idx  = base_q[INDEX_BITS+1:2];
    assign fill_tag  = base_q[ADDR_WIDTH-1:INDEX_BITS+2];
    assign hit       = valid_q[req_idx] && (tag_q[req_idx] == req_tag);
    assign line_word = {mem_din, buf_q};

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
        end else if (ena) begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: if (!flush && fetch_req && !hit) state_d = StFill;
            StFill: if (flush || cnt_q == 3'd4) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Datapath and output next values; flush suppresses everything that would otherwise fire.
    always_comb begin
        cnt_d        = cnt_q;
        buf_d        = buf_q;
        base_d       = base_q;
        mem_valid_d  = 1'b0;
        mem_addr_d   = mem_addr_q;
        inst_valid_d = 1'b0;
        inst_d       = inst_q;
        line_we      = 1'b0;
        if (!flush) begin
            unique case (state_q)
                StIdle: begin
                    if (fetch_req && hit) begin
                        inst_valid_d = 1'b1;
                        inst_d       = data_q[req_idx];
                    end else if (fetch_req) begin
                        base_d      = {fetch_pc[ADDR_WIDTH-1:2], 2'b00};
                        mem_valid_d = 1'b1;
                        mem_addr_d  = {fetch_pc[ADDR_WIDTH-1:2], 2'b00};
                        cnt_d       = 3'd0;
                        buf_d       = '0;
                    end
                end
                StFill: begin
                    cnt_d = cnt_q + 3'd1;
                    // Byte for the address issued in cycle cnt-1 is on mem_din now
                    unique case (cnt_q)
                        3'd1:    buf_d[7:0]   = mem_din;
                        3'd2:    buf_d[15:8]  = mem_din;
                        3'd3:    buf_d[23:16] = mem_din;
                        default: ;
                    endcase
                    if (cnt_q < 3'd3) begin
                        mem_valid_d = 1'b1;
                        mem_addr_d  = mem_addr_q + ADDR_WIDTH'(1);
                    end
                    if (cnt_q == 3'd4) begin
                        line_we      = 1'b1;
                        inst_valid_d = 1'b1;
                        inst_d       = line_word;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q        <= '0;
            buf_q        <= '0;
            base_q       <= '0;
            mem_valid_q  <= 1'b0;
            mem_addr_q   <= '0;
            inst_valid_q <= 1'b0;
            inst_q       <= '0;
            valid_q      <= '0;
        end else if (ena) begin
            cnt_q        <= cnt_d;
            buf_q        <= buf_d;
            base_q       <= base_d;
            mem_valid_q  <= mem_valid_d;
            mem_addr_q   <= mem_addr_d;
            inst_valid_q <= inst_valid_d;
            inst_q       <= inst_d;
            if (flush) begin
                valid_q <= '0;
            end else if (line_we) begin
                valid_q[fill_idx] <= 1'b1;
            end
        end
    end

    // Tag and data arrays need no reset: valid bits gate every use
    always_ff @(posedge clk) begin
        if (ena && line_we) begin
            tag_q[fill_idx]  <= fill_tag;
            data_q[fill_idx] <= line_word;
        end
    end

    assign fetch_ready = (state_q == StIdle);
    assign inst_valid  = inst_valid_q;
    assign inst        = inst_q;
    assign mem_valid   = mem_valid_q;
    assign mem_addr    = mem_addr_q;

endmodule

// File: tb/tb_icache_responder.sv
// Directed bench for icache_responder: a scoreboard queue holds expected instructions
// that are popped whenever inst_valid pulses; timing points are checked inline.
module tb_icache_responder;

    logic        clk = 1'b0;
    logic        rst;
    logic        ena;
    logic        flush;
    logic        fetch_req;
    logic [31:0] fetch_pc;
    logic        fetch_ready;
    logic        inst_valid;
    logic [31:0] inst;
    logic        mem_valid;
    logic [31:0] mem_addr;
    logic [7:0]  mem_din;

    logic [7:0]  mem_b [0:4095];
    logic [31:0] exp_q [$];
    int          n_checks = 0;
    int          n_pass   = 0;

    icache_responder #(.INDEX_BITS(6), .ADDR_WIDTH(32)) dut (
        .clk        (clk),
        .rst        (rst),
        .ena        (ena),
        .flush      (flush),
        .fetch_req  (fetch_req),
        .fetch_pc   (fetch_pc),
        .fetch_ready(fetch_ready),
        .inst_valid (inst_valid),
        .inst       (inst),
        .mem_valid  (mem_valid),
        .mem_addr   (mem_addr),
        .mem_din    (mem_din)
    );

    always #5 clk = ~clk;

    // Byte memory with one-cycle read latency; stalls together with ena
    always @(posedge clk) begin
        if (ena && mem_valid) mem_din <= mem_b[mem_addr[11:0]];
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    // Advance one clock, sample 1ns after the edge, retire any response against the queue.
    task automatic tick();
        @(posedge clk);
        #1;
        if (inst_valid === 1'b1) begin
            if (exp_q.size() == 0) chk("spurious inst_valid", {31'b0, inst_valid}, 32'd0);
            else chk("inst", inst, exp_q.pop_front());
        end
    endtask

    task automatic request(input logic [31:0] pc);
        fetch_req = 1'b1;
        fetch_pc  = pc;
        tick();
        fetch_req = 1'b0;
    endtask

    // Called in cycle N+1 of a miss; walks the fill through the response in N+6.
    task automatic fill_check(input logic [31:0] base);
        for (int k = 0; k < 4; k++) begin
            chk("fill mem_valid", {31'b0, mem_valid}, 32'd1);
            chk("fill mem_addr", mem_addr, base + 32'(k));
            chk("fill fetch_ready", {31'b0, fetch_ready}, 32'd0);
            tick();
        end
        chk("N+5 mem_valid", {31'b0, mem_valid}, 32'd0);
        chk("N+5 fetch_ready", {31'b0, fetch_ready}, 32'd0);
        chk("N+5 inst_valid", {31'b0, inst_valid}, 32'd0);
        tick();
        chk("N+6 inst_valid", {31'b0, inst_valid}, 32'd1);
        chk("N+6 fetch_ready", {31'b0, fetch_ready}, 32'd1);
    endtask

    initial begin
        for (int i = 0; i < 4096; i++) mem_b[i] = 8'(i * 7 + 3);
        {mem_b[12'h103], mem_b[12'h102], mem_b[12'h101], mem_b[12'h100]} = 32'h00500513;
        {mem_b[12'h203], mem_b[12'h202], mem_b[12'h201], mem_b[12'h200]} = 32'hDEADBEEF;
        {mem_b[12'h303], mem_b[12'h302], mem_b[12'h301], mem_b[12'h300]} = 32'h00001237;
        rst = 1'b1; ena = 1'b1; flush = 1'b0; fetch_req = 1'b0; fetch_pc = '0;
        #12;
        chk("reset fetch_ready", {31'b0, fetch_ready}, 32'd1);
        chk("reset inst_valid", {31'b0, inst_valid}, 32'd0);
        chk("reset inst", inst, 32'd0);
        chk("reset mem_valid", {31'b0, mem_valid}, 32'd0);
        chk("reset mem_addr", mem_addr, 32'd0);
        rst = 1'b0;
        tick();

        // Cold miss
        exp_q.push_back(32'h00500513);
        request(32'h100);
        fill_check(32'h100);

        // Hits, back to back, including a non-word-aligned PC
        exp_q.push_back(32'h00500513);
        exp_q.push_back(32'h00500513);
        fetch_req = 1'b1;
        fetch_pc  = 32'h100;
        tick();
        chk("hit0 inst_valid", {31'b0, inst_valid}, 32'd1);
        chk("hit0 mem_valid", {31'b0, mem_valid}, 32'd0);
        fetch_pc = 32'h102;
        tick();
        fetch_req = 1'b0;
        chk("hit1 inst_valid", {31'b0, inst_valid}, 32'd1);
        chk("hit1 mem_valid", {31'b0, mem_valid}, 32'd0);
        chk("hit1 fetch_ready", {31'b0, fetch_ready}, 32'd1);
        tick();
        chk("pulse ends", {31'b0, inst_valid}, 32'd0);
        chk("inst holds", inst, 32'h00500513);

        // Conflict miss evicts 0x100, which then misses again
        exp_q.push_back(32'hDEADBEEF);
        request(32'h200);
        fill_check(32'h200);
        exp_q.push_back(32'h00500513);
        request(32'h100);
        fill_check(32'h100);

        // Flush in N+3 of a fill aborts it
        request(32'h200);
        tick();
        tick();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("flush fetch_ready", {31'b0, fetch_ready}, 32'd1);
        chk("flush mem_valid", {31'b0, mem_valid}, 32'd0);
        chk("flush inst_valid", {31'b0, inst_valid}, 32'd0);
        for (int i = 0; i < 4; i++) tick();
        exp_q.push_back(32'h00500513);
        request(32'h100);
        fill_check(32'h100);

        // Flush beats a simultaneous request on a cached line
        flush = 1'b1;
        request(32'h100);
        flush = 1'b0;
        chk("flush+req inst_valid", {31'b0, inst_valid}, 32'd0);
        chk("flush+req mem_valid", {31'b0, mem_valid}, 32'd0);
        exp_q.push_back(32'h00500513);
        request(32'h100);
        fill_check(32'h100);

        // Stall for 3 cycles once the second byte has been captured
        exp_q.push_back(32'h00001237);
        request(32'h300);
        tick();
        tick();
        tick();
        ena = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("stall mem_addr", mem_addr, 32'h303);
            chk("stall mem_valid", {31'b0, mem_valid}, 32'd1);
            chk("stall inst_valid", {31'b0, inst_valid}, 32'd0);
        end
        ena = 1'b1;
        tick();
        chk("stall N+5 mem_valid", {31'b0, mem_valid}, 32'd0);
        chk("stall N+5 inst_valid", {31'b0, inst_valid}, 32'd0);
        tick();
        chk("stall resp inst_valid", {31'b0, inst_valid}, 32'd1);

        // Asynchronous reset mid-fill
        request(32'h204);
        tick();
        #2;
        rst = 1'b1;
        #1;
        chk("rst mem_valid", {31'b0, mem_valid}, 32'd0);
        chk("rst mem_addr", mem_addr, 32'd0);
        chk("rst fetch_ready", {31'b0, fetch_ready}, 32'd1);
        chk("rst inst_valid", {31'b0, inst_valid}, 32'd0);
        chk("rst inst", inst, 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        exp_q.push_back(32'h00001237);
        request(32'h300);
        fill_check(32'h300);
        exp_q.push_back({mem_b[12'h207], mem_b[12'h206], mem_b[12'h205], mem_b[12'h204]});
        request(32'h204);
        fill_check(32'h204);

        tick();
        chk("scoreboard drained", 32'(exp_q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
